// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - MDIO master shared opcodes, frame field widths and state encoding
package mdio_pkg;

    localparam logic [1:0] OP_ADDR      = 2'b00;
    localparam logic [1:0] OP_WRITE     = 2'b01;
    localparam logic [1:0] OP_READ      = 2'b11;
    localparam logic [1:0] OP_READ_INC  = 2'b10;

    localparam logic [1:0] C22_OP_WRITE = 2'b01;
    localparam logic [1:0] C22_OP_READ  = 2'b10;

    localparam logic [1:0] ST_C45       = 2'b00;
    localparam logic [1:0] ST_C22       = 2'b01;
    localparam logic [1:0] TA_DRIVE     = 2'b10;

    localparam int HDR_BITS   = 14;
    localparam int TA_BITS    = 2;
    localparam int DATA_BITS  = 16;
    localparam int FRAME_BITS = HDR_BITS + TA_BITS + DATA_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_GAP,
        S_RSP,
        S_ILL
    } mdio_state_t;

    // Serial image of everything after the preamble, MSB transmitted first.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [1:0]  st,
        input logic [1:0]  op,
        input logic [4:0]  prtad,
        input logic [4:0]  devad,
        input logic [15:0] data
    );
        return {st, op, prtad, devad, TA_DRIVE, data};
    endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// rtl/mdio_clk_gen.sv - MDC divider with restart, gated mdc and rise/fall ticks
module mdio_clk_gen #(
    parameter int CLK_DIV = 50,
    parameter int DIV_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic mdc,
    output logic tick_rise,
    output logic tick_fall
);

    localparam logic [DIV_W-1:0] HALF_M1 = DIV_W'(CLK_DIV / 2 - 1);

    logic [DIV_W-1:0] cnt;
    logic             phase;
    logic             half_end;

    assign half_end  = (cnt == HALF_M1);
    // Ticks mark the clk edge on which mdc changes level.
    assign tick_rise = half_end & ~phase;
    assign tick_fall = half_end & phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            phase <= 1'b0;
            mdc   <= 1'b0;
        end else if (restart) begin
            cnt   <= '0;
            phase <= 1'b0;
            mdc   <= 1'b0;
        end else begin
            if (half_end) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt   <= cnt + 1'b1;
            end
            mdc <= enable & (half_end ? ~phase : phase);
        end
    end

endmodule

// File: rtl/mdio_master_c45.sv
// rtl/mdio_master_c45.sv - Clause 45 MDIO master; Clause 22 frames when MDIO_CL22_EN is defined
module mdio_master_c45
    import mdio_pkg::*;
#(
    parameter int CLK_DIV   = 50,
    parameter int DIV_W     = 8,
    parameter int PRE_BITS  = 32,
    parameter int IDLE_BITS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic        cmd_cl22,
    input  logic [4:0]  cmd_prtad,
    input  logic [4:0]  cmd_devad,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe
);

    localparam logic [5:0] PRE_CNT  = 6'(PRE_BITS - 1);
    localparam logic [5:0] HDR_CNT  = 6'(HDR_BITS - 1);
    localparam logic [5:0] TA_CNT   = 6'(TA_BITS - 1);
    localparam logic [5:0] DATA_CNT = 6'(DATA_BITS - 1);
    localparam logic [5:0] IDLE_CNT = 6'(IDLE_BITS - 1);

    mdio_state_t           state;
    logic [5:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [15:0]           rd_shift;
    logic                  is_read;
    logic                  ta_err;

    logic                  accept;
    logic                  mdc_en;
    logic                  tick_rise;
    logic                  tick_fall;
    logic                  cmd_rd;
    logic                  cmd_illegal;
    logic [1:0]            cmd_st;
    logic [FRAME_BITS-1:0] cmd_frame;

    assign accept = cmd_valid & cmd_ready;
    assign mdc_en = (state != S_IDLE) && (state != S_RSP) && (state != S_ILL);

`ifdef MDIO_CL22_EN
    assign cmd_st      = cmd_cl22 ? ST_C22 : ST_C45;
    assign cmd_rd      = cmd_cl22 ? (cmd_op == C22_OP_READ) : cmd_op[1];
    assign cmd_illegal = cmd_cl22 && (cmd_op != C22_OP_READ) && (cmd_op != C22_OP_WRITE);
`else
    logic unused_cl22;
    assign unused_cl22 = cmd_cl22;
    assign cmd_st      = ST_C45;
    assign cmd_rd      = cmd_op[1];
    assign cmd_illegal = 1'b0;
`endif

    assign cmd_frame = build_frame(cmd_st, cmd_op, cmd_prtad, cmd_devad, cmd_data);

    mdio_clk_gen #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_clk_gen (
        .clk       (clk),
        .reset     (reset),
        .restart   (accept),
        .enable    (mdc_en),
        .mdc       (mdc),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall)
    );

    // Each bit period's pad value is loaded on the edge that ends the previous period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            rd_shift  <= '0;
            is_read   <= 1'b0;
            ta_err    <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            mdio_o    <= 1'b1;
            mdio_oe   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        is_read   <= cmd_rd;
                        ta_err    <= 1'b0;
                        rd_shift  <= '0;
                        shreg     <= cmd_frame;
                        if (cmd_illegal) begin
                            state <= S_ILL;
                        end else if (PRE_BITS > 0) begin
                            state   <= S_PRE;
                            bit_cnt <= PRE_CNT;
                            mdio_o  <= 1'b1;
                            mdio_oe <= 1'b1;
                        end else begin
                            state   <= S_HDR;
                            bit_cnt <= HDR_CNT;
                            mdio_o  <= cmd_frame[FRAME_BITS-1];
                            mdio_oe <= 1'b1;
                            shreg   <= {cmd_frame[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
                S_PRE: begin
                    if (tick_fall) begin
                        if (bit_cnt == 6'd0) begin
                            state   <= S_HDR;
                            bit_cnt <= HDR_CNT;
                            mdio_o  <= shreg[FRAME_BITS-1];
                            shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                        end else begin
                            bit_cnt <= bit_cnt - 6'd1;
                        end
                    end
                end
                S_HDR: begin
                    if (tick_fall) begin
                        if (bit_cnt == 6'd0) begin
                            state   <= S_TA;
                            bit_cnt <= TA_CNT;
                        end else begin
                            bit_cnt <= bit_cnt - 6'd1;
                        end
                        // Reads release the pad for both turnaround bits.
                        if (is_read && bit_cnt == 6'd0) begin
                            mdio_o  <= 1'b1;
                            mdio_oe <= 1'b0;
                        end else begin
                            mdio_o  <= shreg[FRAME_BITS-1];
                        end
                        shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
                    end
                end
                S_TA: begin
                    if (tick_rise && bit_cnt == 6'd0) begin
                        ta_err <= mdio_i;
                    end
                    if (tick_fall) begin
                        if (bit_cnt == 6'd0) begin
                            state   <= S_DATA;
                            bit_cnt <= DATA_CNT;
                        end else begin
                            bit_cnt <= bit_cnt - 6'd1;
                        end
                        if (!is_read) begin
                            mdio_o <= shreg[FRAME_BITS-1];
                            shreg  <= {shreg[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
                S_DATA: begin
                    if (tick_rise) begin
                        rd_shift <= {rd_shift[14:0], mdio_i};
                    end
                    if (tick_fall) begin
                        if (bit_cnt == 6'd0) begin
                            state   <= S_GAP;
                            bit_cnt <= IDLE_CNT;
                            mdio_o  <= 1'b1;
                            mdio_oe <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt - 6'd1;
                            if (!is_read) begin
                                mdio_o <= shreg[FRAME_BITS-1];
                                shreg  <= {shreg[FRAME_BITS-2:0], 1'b0};
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (tick_fall) begin
                        if (bit_cnt == 6'd0) begin
                            state     <= S_RSP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= is_read ? rd_shift : 16'h0000;
                            rsp_err   <= is_read & ta_err;
                        end else begin
                            bit_cnt <= bit_cnt - 6'd1;
                        end
                    end
                end
                S_ILL: begin
                    state     <= S_RSP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= 16'h0000;
                    rsp_err   <= 1'b1;
                end
                S_RSP: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    mdio_o    <= 1'b1;
                    mdio_oe   <= 1'b0;
                end
            endcase
        end
    end

endmodule
